forward_unit_param: RTL and testbench
=====================================

FORWARD_UNIT_PARAM -- requirements
Module: forward_unit_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 The block SHALL have parameter RADDR_W, default 4, meaning register address width.
REQ-003 The block SHALL have parameter NPORTS, default 2, meaning number of source operand ports.
REQ-004 The block SHALL have parameter NSTAGES, default 2, meaning number of downstream forwarding stages; index 0 is EX, the highest index is WB.
REQ-005 The block SHALL have port clk  in  1  system clock; one clock, all state on its rising edge.
REQ-006 The block SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port id_valid  in  1  instruction presented in decode.
REQ-008 The block SHALL have ports id_dest  in  RADDR_W, id_we  in  1 and id_load  in  1: decode destination, write enable and load flag.
REQ-009 The block SHALL have port id_src  in  NPORTS x RADDR_W  source register per port.
REQ-010 The block SHALL have port id_src_use  in  NPORTS  per-port register-use flag; 0 means immediate/unused, never forwarded.
REQ-011 The block SHALL have port id_opnd  in  NPORTS x DATA_W  register-file read data.
REQ-012 The block SHALL have port stg_res  in  NSTAGES x DATA_W  result currently held by each downstream stage.
REQ-013 The block SHALL have port flush  in  1  kill all in-flight instructions.
REQ-014 The block SHALL have ports stall  out  1 (combinational), ex_valid  out  1, ex_opnd  out  NPORTS x DATA_W, fwd_sel  out  NPORTS x $clog2(NSTAGES+1).

Function
REQ-015 The block SHALL keep a tag pipeline tag[0..NSTAGES-1] {valid, we, load, dest}; tag[k] describes the instruction whose result is on stg_res[k].
REQ-016 Each cycle, tag[k] SHALL load tag[k-1] for k>=1; tag[0] SHALL load id info when id_valid & ~stall, else a bubble (valid=0).
REQ-017 A port SHALL match stage k when id_src_use=1, tag[k].valid, tag[k].we and tag[k].dest==id_src.
REQ-018 Among matching stages, the lowest index (youngest) SHALL win; with no match, id_opnd SHALL be selected.
REQ-019 stall SHALL be 1 when id_valid and any port matches stage 0 with tag[0].load=1; loads SHALL forward only from stage >=1.
REQ-020 On a non-stalled, non-flushed valid cycle, ex_opnd SHALL register the selected values, ex_valid 1, fwd_sel the winning stage+1 (0 = register file); otherwise ex_valid SHALL register 0 and ex_opnd hold.
REQ-021 A stall SHALL last exactly one cycle per load-use hazard (the bubble clears the stage-0 match).
REQ-022 flush SHALL invalidate all tags and register ex_valid 0 next cycle, taking priority over id_valid and stall.
REQ-023 Register address 0 SHALL be treated like any other register (no hardwired zero).

Reset
REQ-024 rst SHALL clear all tags to invalid, ex_valid 0, ex_opnd 0, fwd_sel 0 and counters 0, immediately and independent of clk.
REQ-025 Reset asserted mid-stall SHALL drop stall to 0 because the tags are invalid.

Configuration
REQ-026 With FWD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt (16) and fwd_cnt (16): saturating counts of stall cycles and of registered cycles with any fwd_sel!=0.
REQ-027 Without FWD_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package fwd_pkg SHALL hold stage_tag_t and default width constants.
REQ-029 Sub-module fwd_port_mux SHALL implement the per-port priority compare/select and be instantiated NPORTS times.

Verification
REQ-030 ADD r3 issued, next ADD uses r3 on port0, stg_res[0]=0x11 -> ex_opnd[0]=0x11, fwd_sel[0]=1, stall=0.
REQ-031 r5 written in stage 0 (0xAA) and stage 1 (0xBB), src r5 -> 0xAA selected (youngest).
REQ-032 LOAD r2 then a use of r2 -> stall=1 for one cycle, bubble inserted, then ex_opnd[0]=stg_res[1], fwd_sel=2.
REQ-033 Port1 src=r3 with id_src_use=0 while r3 is in flight -> ex_opnd[1]=id_opnd[1], fwd_sel[1]=0.
REQ-034 flush together with a stall condition -> next cycle ex_valid=0, all tags invalid, stall=0.
REQ-035 rst pulsed mid-pipeline, then FWD_PERF_CNT_EN build with 70000 stall cycles -> outputs zeroed after reset; stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and default widths for the operand forwarding unit.
package fwd_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RADDR_W = 4;
    localparam int unsigned DEF_NPORTS  = 2;
    localparam int unsigned DEF_NSTAGES = 2;
    localparam int unsigned TAG_DEST_W  = 8;   // widest supported register address
    localparam int unsigned CNT_W       = 16;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic                  load;
        logic [TAG_DEST_W-1:0] dest;
    } stage_tag_t;

endpackage

// File: rtl/fwd_port_mux.sv
// Per-port forwarding select: youngest matching downstream stage wins, else register file.
module fwd_port_mux
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    parameter int unsigned NSTAGES = DEF_NSTAGES,
    parameter int unsigned SEL_W   = $clog2(DEF_NSTAGES + 1)
) (
    input  stage_tag_t [NSTAGES-1:0]             tags,
    input  logic       [RADDR_W-1:0]             src,
    input  logic                                 src_use,
    input  logic       [DATA_W-1:0]              opnd,
    input  logic       [NSTAGES-1:0][DATA_W-1:0] stg_res,
    output logic       [DATA_W-1:0]              value,
    output logic       [SEL_W-1:0]               sel,
    output logic                                 hazard
);

    logic [NSTAGES-1:0] match;

    always_comb begin
        match = '0;
        for (int unsigned k = 0; k < NSTAGES; k++) begin
            match[k] = src_use && tags[k].valid && tags[k].we &&
                       (tags[k].dest == TAG_DEST_W'(src));
        end
    end

    // Walk oldest to youngest so the lowest matching index is the last to assign.
    always_comb begin
        value = opnd;
        sel   = '0;
        for (int unsigned i = 0; i < NSTAGES; i++) begin
            if (match[NSTAGES-1-i]) begin
                value = stg_res[NSTAGES-1-i];
                sel   = SEL_W'(NSTAGES - i);
            end
        end
    end

    // A load in EX has no result yet; forwarding must wait for a later stage.
    assign hazard = match[0] && tags[0].load;

endmodule

// File: rtl/forward_unit_param.sv
// Operand forwarding / load-use interlock with a tag pipeline shadowing the downstream stages.
// Optional performance counters are enabled by defining FWD_PERF_CNT_EN.
module forward_unit_param
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    parameter int unsigned NPORTS  = DEF_NPORTS,
    parameter int unsigned NSTAGES = DEF_NSTAGES
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            id_valid,
    input  logic [RADDR_W-1:0]                              id_dest,
    input  logic                                            id_we,
    input  logic                                            id_load,
    input  logic [NPORTS-1:0][RADDR_W-1:0]                  id_src,
    input  logic [NPORTS-1:0]                               id_src_use,
    input  logic [NPORTS-1:0][DATA_W-1:0]                   id_opnd,
    input  logic [NSTAGES-1:0][DATA_W-1:0]                  stg_res,
    input  logic                                            flush,
    output logic                                            stall,
    output logic                                            ex_valid,
    output logic [NPORTS-1:0][DATA_W-1:0]                   ex_opnd,
    output logic [NPORTS-1:0][$clog2(NSTAGES+1)-1:0]        fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]                                stall_cnt,
    output logic [CNT_W-1:0]                                fwd_cnt
`endif
);

    localparam int unsigned SEL_W = $clog2(NSTAGES + 1);

    stage_tag_t [NSTAGES-1:0]             tags;
    logic       [NPORTS-1:0][DATA_W-1:0]  sel_value;
    logic       [NPORTS-1:0][SEL_W-1:0]   sel_stage;
    logic       [NPORTS-1:0]              port_hazard;
    logic       [NPORTS-1:0]              port_fwd;
    logic                                 issue;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_port_mux #(
            .DATA_W  (DATA_W),
            .RADDR_W (RADDR_W),
            .NSTAGES (NSTAGES),
            .SEL_W   (SEL_W)
        ) u_mux (
            .tags    (tags),
            .src     (id_src[p]),
            .src_use (id_src_use[p]),
            .opnd    (id_opnd[p]),
            .stg_res (stg_res),
            .value   (sel_value[p]),
            .sel     (sel_stage[p]),
            .hazard  (port_hazard[p])
        );
        assign port_fwd[p] = |sel_stage[p];
    end

    assign stall = id_valid && (|port_hazard);
    assign issue = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags <= '0;
        end else if (flush) begin
            tags <= '0;
        end else begin
            for (int unsigned k = 1; k < NSTAGES; k++) begin
                tags[k] <= tags[k-1];
            end
            if (id_valid && !stall) begin
                tags[0].valid <= 1'b1;
                tags[0].we    <= id_we;
                tags[0].load  <= id_load;
                tags[0].dest  <= TAG_DEST_W'(id_dest);
            end else begin
                tags[0] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_opnd  <= '0;
            fwd_sel  <= '0;
        end else begin
            ex_valid <= issue;
            if (issue) begin
                ex_opnd <= sel_value;
                fwd_sel <= sel_stage;
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (issue && (|port_fwd) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = |port_fwd;
`endif

endmodule

// File: tb/tb_forward_unit_param.sv
// Bench for forward_unit_param: directed vector table, randomized run against a slot-history model.
module tb_forward_unit_param;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NP = 2;
    localparam int NS = 3;
    localparam int SW = $clog2(NS + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        id_valid;
    logic [AW-1:0]               id_dest;
    logic                        id_we;
    logic                        id_load;
    logic [NP-1:0][AW-1:0]       id_src;
    logic [NP-1:0]               id_src_use;
    logic [NP-1:0][DW-1:0]       id_opnd;
    logic [NS-1:0][DW-1:0]       stg_res;
    logic                        flush;
    logic                        stall;
    logic                        ex_valid;
    logic [NP-1:0][DW-1:0]       ex_opnd;
    logic [NP-1:0][SW-1:0]       fwd_sel;
`ifdef FWD_PERF_CNT_EN
    logic [15:0]                 stall_cnt;
    logic [15:0]                 fwd_cnt;
`endif

    forward_unit_param #(
        .DATA_W  (DW),
        .RADDR_W (AW),
        .NPORTS  (NP),
        .NSTAGES (NS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_dest    (id_dest),
        .id_we      (id_we),
        .id_load    (id_load),
        .id_src     (id_src),
        .id_src_use (id_src_use),
        .id_opnd    (id_opnd),
        .stg_res    (stg_res),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_opnd    (ex_opnd),
        .fwd_sel    (fwd_sel)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        bit          iv;
        logic [3:0]  dest;
        bit          we;
        bit          ld;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [1:0]  um;
        logic [31:0] r0, r1, r2;
        bit          fl;
        bit          e_stall;
        bit          e_valid;
        logic [31:0] e_op0, e_op1;
        logic [1:0]  e_sel0, e_sel1;
    } vec_t;

    function automatic vec_t mk(bit iv, int dest, bit we, bit ld, int s0, int s1, int um,
                                int r0, int r1, int r2, bit fl,
                                bit es, bit ev, int o0, int o1, int sl0, int sl1);
        vec_t v;
        v.iv = iv; v.dest = 4'(dest); v.we = we; v.ld = ld;
        v.s0 = 4'(s0); v.s1 = 4'(s1); v.um = 2'(um);
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.fl = fl;
        v.e_stall = es; v.e_valid = ev; v.e_op0 = o0; v.e_op1 = o1;
        v.e_sel0 = 2'(sl0); v.e_sel1 = 2'(sl1);
        return v;
    endfunction

    task automatic drive(input bit iv, input int dest, input bit we, input bit ld,
                         input int s0, input int s1, input int um,
                         input int op0, input int op1,
                         input int r0, input int r1, input int r2, input bit fl);
        id_valid = iv; id_dest = 4'(dest); id_we = we; id_load = ld;
        id_src[0] = 4'(s0); id_src[1] = 4'(s1); id_src_use = 2'(um);
        id_opnd[0] = op0; id_opnd[1] = op1;
        stg_res[0] = r0; stg_res[1] = r1; stg_res[2] = r2;
        flush = fl;
    endtask

    // Reference model: the last NS issue slots, slot 0 being the most recent.
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int dest;
    } slot_t;

    slot_t       hist[NS];
    bit          m_valid;
    logic [31:0] m_op[NP];
    int          m_sel[NP];
    int          m_stall_cnt;
    int          m_fwd_cnt;

    task automatic model_clear();
        foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
        m_valid = 0;
        foreach (m_op[p]) begin m_op[p] = 0; m_sel[p] = 0; end
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
    endtask

    vec_t tbl[13];

    initial begin
        bit          hold;
        bit          e_stall;
        bit          hz;
        bit          issue;
        bit          any_fwd;
        logic [31:0] e_val[NP];
        int          e_sel[NP];
        int          r_iv, r_dest, r_we, r_ld, r_s[NP], r_um, r_op[NP];
        int          rr[NS];
        bit          r_fl;

        tbl[0]  = mk(1, 3, 1, 0, 1, 2, 2'b11, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[1]  = mk(1, 4, 1, 0, 3, 3, 2'b01, 'h11,  0,     0,     0, 0, 1, 32'h11,  32'h200, 1, 0);
        tbl[2]  = mk(1, 5, 1, 0, 1, 2, 2'b00, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[3]  = mk(1, 5, 1, 0, 1, 2, 2'b00, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[4]  = mk(1, 6, 1, 0, 5, 3, 2'b11, 'hAA,  'hBB,  'hCC,  0, 0, 1, 32'hAA,  32'h200, 1, 0);
        tbl[5]  = mk(1, 2, 1, 1, 1, 2, 2'b00, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[6]  = mk(1, 7, 1, 0, 2, 1, 2'b01, 0,     0,     0,     0, 1, 0, 32'h100, 32'h200, 0, 0);
        tbl[7]  = mk(1, 7, 1, 0, 2, 1, 2'b01, 'h31,  'h32,  'h33,  0, 0, 1, 32'h32,  32'h200, 2, 0);
        tbl[8]  = mk(1, 9, 1, 1, 1, 2, 2'b00, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[9]  = mk(1, 8, 1, 0, 9, 1, 2'b01, 0,     0,     0,     1, 1, 0, 32'h100, 32'h200, 0, 0);
        tbl[10] = mk(1, 10, 1, 0, 9, 1, 2'b01, 'h41, 'h42,  'h43,  0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[11] = mk(1, 0, 1, 0, 1, 2, 2'b00, 0,     0,     0,     0, 0, 1, 32'h100, 32'h200, 0, 0);
        tbl[12] = mk(1, 8, 1, 0, 0, 0, 2'b11, 'h55,  0,     0,     0, 0, 1, 32'h55,  32'h55,  1, 1);

        // Reset state, with a valid instruction presented while reset is held
        rst = 1'b1;
        drive(1, 1, 1, 0, 1, 2, 3, 'h100, 'h200, 1, 2, 3, 0);
        @(posedge clk); #1;
        chk("reset_stall",    64'(stall),      0);
        chk("reset_ex_valid", 64'(ex_valid),   0);
        chk("reset_ex_opnd0", 64'(ex_opnd[0]), 0);
        chk("reset_ex_opnd1", 64'(ex_opnd[1]), 0);
        chk("reset_fwd_sel0", 64'(fwd_sel[0]), 0);
        chk("reset_fwd_sel1", 64'(fwd_sel[1]), 0);
`ifdef FWD_PERF_CNT_EN
        chk("reset_stall_cnt", 64'(stall_cnt), 0);
        chk("reset_fwd_cnt",   64'(fwd_cnt),   0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].iv, tbl[i].dest, tbl[i].we, tbl[i].ld, tbl[i].s0, tbl[i].s1, tbl[i].um,
                  'h100, 'h200, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].fl);
            #3;
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ex_valid", i), 64'(ex_valid),   64'(tbl[i].e_valid));
            chk($sformatf("vec%0d_ex_opnd0", i), 64'(ex_opnd[0]), 64'(tbl[i].e_op0));
            chk($sformatf("vec%0d_ex_opnd1", i), 64'(ex_opnd[1]), 64'(tbl[i].e_op1));
            chk($sformatf("vec%0d_fwd_sel0", i), 64'(fwd_sel[0]), 64'(tbl[i].e_sel0));
            chk($sformatf("vec%0d_fwd_sel1", i), 64'(fwd_sel[1]), 64'(tbl[i].e_sel1));
        end

        // Randomized run against the slot-history model
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_clear();
        hold = 0;
        r_iv = 0; r_dest = 0; r_we = 0; r_ld = 0; r_um = 0;
        foreach (r_s[p]) begin r_s[p] = 0; r_op[p] = 0; end
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                r_iv   = ($urandom_range(0, 9) < 8) ? 1 : 0;
                r_dest = $urandom_range(0, 3);
                r_we   = ($urandom_range(0, 3) != 0) ? 1 : 0;
                r_ld   = ($urandom_range(0, 9) < 3) ? 1 : 0;
                r_um   = $urandom_range(0, 3);
                foreach (r_s[p]) begin
                    r_s[p]  = $urandom_range(0, 3);
                    r_op[p] = $urandom;
                end
            end
            foreach (rr[k]) rr[k] = $urandom;
            r_fl = ($urandom_range(0, 19) == 0);
            drive(r_iv[0], r_dest, r_we[0], r_ld[0], r_s[0], r_s[1], r_um,
                  r_op[0], r_op[1], rr[0], rr[1], rr[2], r_fl);

            hz = 0;
            for (int p = 0; p < NP; p++) begin
                e_val[p] = r_op[p];
                e_sel[p] = 0;
                if (r_um[p]) begin
                    for (int k = 0; k < NS; k++) begin
                        if (hist[k].v && hist[k].we && hist[k].dest == r_s[p]) begin
                            e_val[p] = rr[k];
                            e_sel[p] = k + 1;
                            if (k == 0 && hist[0].ld) hz = 1;
                            break;
                        end
                    end
                end
            end
            e_stall = r_iv[0] && hz;
            #3;
            chk("rnd_stall", 64'(stall), 64'(e_stall));
            @(posedge clk); #1;

            issue = r_iv[0] && !e_stall && !r_fl;
            if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
            if (r_fl) begin
                foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
            end else begin
                for (int k = NS - 1; k > 0; k--) hist[k] = hist[k-1];
                if (r_iv[0] && !e_stall) hist[0] = '{1, r_we[0], r_ld[0], r_dest};
                else hist[0] = '{0, 0, 0, 0};
            end
            m_valid = issue;
            if (issue) begin
                any_fwd = 0;
                for (int p = 0; p < NP; p++) begin
                    m_op[p]  = e_val[p];
                    m_sel[p] = e_sel[p];
                    if (e_sel[p] != 0) any_fwd = 1;
                end
                if (any_fwd && m_fwd_cnt < 65535) m_fwd_cnt++;
            end
            hold = e_stall && !r_fl;

            chk("rnd_ex_valid", 64'(ex_valid),   64'(m_valid));
            chk("rnd_ex_opnd0", 64'(ex_opnd[0]), 64'(m_op[0]));
            chk("rnd_ex_opnd1", 64'(ex_opnd[1]), 64'(m_op[1]));
            chk("rnd_fwd_sel0", 64'(fwd_sel[0]), 64'(m_sel[0]));
            chk("rnd_fwd_sel1", 64'(fwd_sel[1]), 64'(m_sel[1]));
        end
`ifdef FWD_PERF_CNT_EN
        chk("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        chk("rnd_fwd_cnt",   64'(fwd_cnt),   64'(m_fwd_cnt));
`endif

        // Asynchronous reset in the middle of a load-use stall
        drive(1, 2, 1, 1, 1, 1, 0, 'h100, 'h200, 1, 2, 3, 0);
        @(posedge clk); #1;
        chk("mid_load_ex_valid", 64'(ex_valid), 1);
        drive(1, 3, 1, 0, 2, 1, 1, 'h100, 'h200, 1, 2, 3, 0);
        #2;
        chk("mid_stall_before_rst", 64'(stall), 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_stall",    64'(stall),      0);
        chk("mid_rst_ex_valid", 64'(ex_valid),   0);
        chk("mid_rst_ex_opnd0", 64'(ex_opnd[0]), 0);
        chk("mid_rst_ex_opnd1", 64'(ex_opnd[1]), 0);
        chk("mid_rst_fwd_sel0", 64'(fwd_sel[0]), 0);
        chk("mid_rst_fwd_sel1", 64'(fwd_sel[1]), 0);
`ifdef FWD_PERF_CNT_EN
        chk("mid_rst_stall_cnt", 64'(stall_cnt), 0);
        chk("mid_rst_fwd_cnt",   64'(fwd_cnt),   0);
`endif
        #2 rst = 1'b0;

`ifdef FWD_PERF_CNT_EN
        // Self-dependent load: alternates issue and stall, over 70000 stall cycles
        drive(1, 1, 1, 1, 1, 1, 1, 'h100, 'h200, 1, 2, 3, 0);
        for (int n = 0; n < 140010; n++) @(posedge clk);
        #1;
        chk("sat_stall_cnt", 64'(stall_cnt), 64'hFFFF);
        chk("sat_fwd_cnt",   64'(fwd_cnt),   64'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
